// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: binary-to-BCD converter feeding a multiplexed 7-segment digit scanner
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 16,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  value_valid,
  input  logic [DATA_W-1:0]     value_data,
  output logic                  value_ready,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic [3:0]            digit_num,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  digit_dp,
  output logic                  overflow
);
  localparam int BCD_RAW = DATA_W * 3 / 10 + 1;
  localparam int BCD_N   = BCD_RAW > NUM_DIGITS ? BCD_RAW : NUM_DIGITS;
  localparam int BW      = 4 * BCD_N;
  localparam int DW      = 4 * NUM_DIGITS;
  localparam int IW      = $clog2(NUM_DIGITS);
  localparam int CW      = $clog2(SCAN_DIV);
  localparam int TW      = $clog2(DATA_W + 1);
  localparam logic [63:0] LIMIT = 64'(10 ** NUM_DIGITS) - 64'd1;

  typedef enum logic {IDLE, CONV} state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_W-1:0]     r_bin;
  logic [BW-1:0]         r_bcd, w_adj, w_bcd_nxt;
  logic [TW-1:0]         r_it;
  logic                  r_ovf_pend, r_ovf;
  logic [DW-1:0]         r_disp, w_disp_new, w_disp_nxt;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx, w_idx_nxt;
  logic [NUM_DIGITS-1:0] r_sel;
  logic [3:0]            r_num;
  logic                  r_dp;
  logic [NUM_DIGITS:0]   w_lz;
  logic                  w_last, w_xfer, w_load, w_adv, w_blank;

  for (genvar i = 0; i < BCD_N; i++) begin : g_adj
    assign w_adj[4*i +: 4] = r_bcd[4*i +: 4] >= 4'd5 ? r_bcd[4*i +: 4] + 4'd3 : r_bcd[4*i +: 4];
  end

  assign w_bcd_nxt  = {w_adj[BW-2:0], r_bin[DATA_W-1]};
  assign w_last     = r_it == TW'(DATA_W - 1);
  assign w_xfer     = value_valid && value_ready;
  assign w_disp_new = r_ovf_pend ? {NUM_DIGITS{4'd9}} : w_bcd_nxt[DW-1:0];
  assign w_disp_nxt = w_load ? w_disp_new : r_disp;
  assign w_adv      = r_cnt == CW'(SCAN_DIV - 1);
  assign w_idx_nxt  = w_adv ? (r_idx == IW'(NUM_DIGITS - 1) ? '0 : r_idx + 1'b1) : r_idx;

  // a digit is a leading zero when it and every higher digit are zero
  assign w_lz[NUM_DIGITS] = 1'b1;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
    assign w_lz[i] = (w_disp_nxt[4*i +: 4] == 4'd0) && w_lz[i+1];
  end

  assign w_blank = blank_lz && (w_idx_nxt != '0) && w_lz[w_idx_nxt];

  // conversion state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // leave IDLE on a transfer, return after the last shift
  always_comb begin
    w_state_nxt = r_state == IDLE ? (value_valid ? CONV : IDLE) : (w_last ? IDLE : CONV);
  end

  // handshake and display-load strobes decoded from state
  always_comb begin
    value_ready = r_state == IDLE;
    w_load      = r_state == CONV && w_last;
  end

  // double-dabble datapath; display and overflow only change on the final shift
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_it       <= '0;
      r_ovf_pend <= 1'b0;
      r_disp     <= '0;
      r_ovf      <= 1'b0;
    end else if (w_xfer) begin
      r_bin      <= value_data;
      r_bcd      <= '0;
      r_it       <= '0;
      r_ovf_pend <= 64'(value_data) > LIMIT;
    end else if (r_state == CONV) begin
      r_bin <= r_bin << 1;
      r_bcd <= w_bcd_nxt;
      r_it  <= r_it + 1'b1;
      if (w_load) begin
        r_disp <= w_disp_new;
        r_ovf  <= r_ovf_pend;
      end
    end
  end

  // digit scan: outputs refresh on slot advance or when the shown value reloads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_sel <= NUM_DIGITS'(1);
      r_num <= 4'd0;
      r_dp  <= 1'b0;
    end else begin
      r_cnt <= w_adv ? '0 : r_cnt + 1'b1;
      r_idx <= w_idx_nxt;
      if (w_adv || w_load) begin
        r_sel <= w_blank ? '0 : NUM_DIGITS'(1) << w_idx_nxt;
        r_num <= w_blank ? 4'hF : w_disp_nxt[{w_idx_nxt, 2'b00} +: 4];
        r_dp  <= !w_blank && dp_mask[w_idx_nxt];
      end
    end
  end

  assign digit_sel = r_sel;
  assign digit_num = r_num;
  assign digit_dp  = r_dp;
  assign overflow  = r_ovf;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        value_valid = 1'b0;
  logic [15:0] value_data = '0;
  logic        value_ready;
  logic        blank_lz = 1'b0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  digit_num;
  logic [3:0]  digit_sel;
  logic        digit_dp;
  logic        overflow;
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;

  seg_scan_ctrl #(.NUM_DIGITS(4), .DATA_W(16), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .value_valid(value_valid), .value_data(value_data),
    .value_ready(value_ready), .blank_lz(blank_lz), .dp_mask(dp_mask),
    .digit_num(digit_num), .digit_sel(digit_sel), .digit_dp(digit_dp), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // non-reset edges since reset release; slot k starts when cyc%4==0 and (cyc/4)%4==k
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_digit(input int k, input logic [3:0] es, input logic [3:0] en,
                             input logic ed, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(cyc % 4 == 0 && (cyc / 4) % 4 == k) && n < 40);
    chk({tag, "_slot"}, 16'(n < 40), 16'd1);
    chk({tag, "_sel"}, 16'(digit_sel), 16'(es));
    chk({tag, "_num"}, 16'(digit_num), 16'(en));
    chk({tag, "_dp"}, 16'(digit_dp), 16'(ed));
  endtask

  task automatic digits(input logic [15:0] disp, input logic [3:0] blank,
                        input logic [3:0] dpm, input string tag);
    for (int k = 0; k < 4; k++)
      check_digit(k, blank[k] ? 4'b0000 : 4'(1 << k), blank[k] ? 4'hF : disp[4*k +: 4],
                  blank[k] ? 1'b0 : dpm[k], $sformatf("%s_d%0d", tag, k));
  endtask

  task automatic send(input logic [15:0] v, input bit noise, input string tag);
    int n = 0;
    int lat = 0;
    while (!value_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    value_valid = 1'b1;
    value_data  = v;
    @(negedge clk);
    while (!value_ready && lat < 40) begin
      lat++;
      value_valid = noise && lat >= 2 && lat < 8;
      value_data  = noise ? 16'd42 : v;
      @(negedge clk);
    end
    value_valid = 1'b0;
    chk({tag, "_lat"}, 16'(lat), 16'd16);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 16'(value_ready), 16'd1);
    chk("rst_sel", 16'(digit_sel), 16'b0001);
    chk("rst_num", 16'(digit_num), 16'd0);
    chk("rst_ovf", 16'(overflow), 16'd0);
    rst_n = 1'b1;
    digits(16'h0000, 4'b0000, 4'b0000, "scan0");

    send(16'd1234, 1'b0, "v1234");
    chk("v1234_ovf", 16'(overflow), 16'd0);
    digits(16'h1234, 4'b0000, 4'b0000, "v1234");

    blank_lz = 1'b1;
    send(16'd7, 1'b0, "v7");
    digits(16'h0007, 4'b1110, 4'b0000, "v7_blank");
    blank_lz = 1'b0;
    digits(16'h0007, 4'b0000, 4'b0000, "v7_noblank");
    blank_lz = 1'b1;
    send(16'd0, 1'b0, "v0");
    digits(16'h0000, 4'b1110, 4'b0000, "v0_blank");
    blank_lz = 1'b0;

    send(16'd12345, 1'b0, "v12345");
    chk("v12345_ovf", 16'(overflow), 16'd1);
    digits(16'h9999, 4'b0000, 4'b0000, "v12345");
    send(16'd9999, 1'b0, "v9999");
    chk("v9999_ovf", 16'(overflow), 16'd0);
    digits(16'h9999, 4'b0000, 4'b0000, "v9999");

    send(16'd1234, 1'b1, "v1234n");
    dp_mask = 4'b0100;
    digits(16'h1234, 4'b0000, 4'b0100, "v1234n");
    dp_mask = 4'b0000;

    value_valid = 1'b1;
    value_data  = 16'd5678;
    @(negedge clk);
    value_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_busy", 16'(value_ready), 16'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ready", 16'(value_ready), 16'd1);
    chk("abort_sel", 16'(digit_sel), 16'b0001);
    chk("abort_num", 16'(digit_num), 16'd0);
    chk("abort_ovf", 16'(overflow), 16'd0);
    rst_n = 1'b1;
    digits(16'h0000, 4'b0000, 4'b0000, "abort");
    send(16'd5678, 1'b0, "v5678");
    digits(16'h5678, 4'b0000, 4'b0000, "v5678");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
